// File: rtl/otter_mem2_arbiter_pkg.sv
// Shared types for the OTTER memory port 2 arbiter.
//   arb_state_t : arbitration FSM states (normal arbitration / B owns port)
//   arb_owner_t : owner tag of the read issued in the previous cycle
//   mem_req_t   : access fields carried by each requester port
package otter_arb_pkg;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } arb_owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } mem_req_t;

endpackage

// File: rtl/otter_mem2_arbiter_if.sv
// Requester port of the memory port 2 arbiter; one instance per requester.
//   req    : access request (fields in cmd must stay stable until gnt)
//   lock   : keep port ownership after the current grant (only B uses it)
//   cmd    : we/addr/din/size/sign of the access
//   gnt    : access issued this cycle
//   rvalid : rdata holds the result of this requester's read of last cycle
//   rdata  : read data, 0 when rvalid is low
// master modport = requester side, slave modport = arbiter side.
interface otter_mem2_arbiter_if;
  import otter_arb_pkg::*;

  logic        req;
  logic        lock;
  mem_req_t    cmd;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, lock, cmd, input gnt, rvalid, rdata);
  modport slave  (input req, lock, cmd, output gnt, rvalid, rdata);

endinterface

// File: rtl/otter_mem2_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles in which B waits while A is granted.
//   clk, rst_n : clock, async active-low reset
//   inc        : B requesting while A was granted
//   clr        : B granted or B not requesting
//   at_max     : count has reached MAX_WAIT, B must be forced through
module otter_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != W'(MAX_WAIT)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == W'(MAX_WAIT));

endmodule

// File: rtl/otter_mem2_arbiter.sv
// Arbiter for memory port 2 between the pipeline MEM stage (a_port) and a
// secondary bus master (b_port). One access per cycle, read data one cycle
// after issue, stall toward the pipeline whenever the MEM stage is denied.
//   clk, rst_n          : clock, async active-low reset (released on next clk)
//   a_port, b_port      : requester ports (slave modport)
//   stall               : a_port.req & ~a_port.gnt
//   mem_read2/mem_write2: memory port 2 strobes
//   mem_addr2/mem_din2/mem_size/mem_sign : fields of the winning access
//   mem_dout2           : synchronous memory read data
// Build option: OTTER_ARB_STARVE_EN adds the starvation guard that forces B
// through after MAX_WAIT consecutive lost cycles; without it A has strict
// priority outside of a B lock.
module otter_mem2_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  otter_mem2_arbiter_if.slave  a_port,
  otter_mem2_arbiter_if.slave  b_port,
  output logic                 stall,
  output logic                 mem_read2,
  output logic                 mem_write2,
  output logic [31:0]          mem_addr2,
  output logic [31:0]          mem_din2,
  output logic [1:0]           mem_size,
  output logic                 mem_sign,
  input  logic [31:0]          mem_dout2
);

  arb_state_t state;
  arb_owner_t owner;
  logic       run;
  logic       starve;
  logic       a_gnt;
  logic       b_gnt;
  logic       any_gnt;
  mem_req_t   sel;

`ifdef OTTER_ARB_STARVE_EN
  otter_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (b_port.req & a_gnt),
    .clr    (b_gnt | ~b_port.req),
    .at_max (starve)
  );
`else
  // MAX_WAIT of 0 is outside the legal range, so this term is constant 0
  // and A keeps strict priority in ARB.
  assign starve = (MAX_WAIT == 0);
`endif

  // run holds grants off until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      state <= ARB;
      owner <= OWN_NONE;
    end else begin
      run <= 1'b1;
      case (state)
        ARB:     if (b_gnt && b_port.lock) state <= LOCKED;
        LOCKED:  if (!b_port.lock) state <= ARB;
        default: state <= ARB;
      endcase
      if (a_gnt && !a_port.cmd.we) begin
        owner <= OWN_A;
      end else if (b_gnt && !b_port.cmd.we) begin
        owner <= OWN_B;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // A wins in ARB unless the guard forces a waiting B through.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (run) begin
      if (state == LOCKED) begin
        b_gnt = b_port.req;
      end else if (a_port.req && !(b_port.req && starve)) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = b_port.req;
      end
    end
  end

  always_comb begin
    sel = '0;
    if (a_gnt) begin
      sel = a_port.cmd;
    end else if (b_gnt) begin
      sel = b_port.cmd;
    end
  end

  assign any_gnt    = a_gnt | b_gnt;
  assign mem_read2  = any_gnt & ~sel.we;
  assign mem_write2 = any_gnt & sel.we;
  assign mem_addr2  = sel.addr;
  assign mem_din2   = sel.din;
  assign mem_size   = sel.size;
  assign mem_sign   = sel.sign;

  assign stall = a_port.req & ~a_gnt;

  assign a_port.gnt    = a_gnt;
  assign b_port.gnt    = b_gnt;
  assign a_port.rvalid = (owner == OWN_A);
  assign b_port.rvalid = (owner == OWN_B);
  assign a_port.rdata  = (owner == OWN_A) ? mem_dout2 : 32'h0;
  assign b_port.rdata  = (owner == OWN_B) ? mem_dout2 : 32'h0;

endmodule

// File: tb/tb_otter_mem2_arbiter.sv
// Self-checking bench for otter_mem2_arbiter: fixed vector table, hand-written
// multi-cycle sequences (contention, lock burst, interleave, reset mid-read)
// and a randomized phase checked against a rule-level reference model.
module tb_otter_mem2_arbiter;
  import otter_arb_pkg::*;

  localparam int MAX_WAIT = 4;
`ifdef OTTER_ARB_STARVE_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef struct {
    logic        rstN;
    logic        aReq;
    logic        aWe;
    logic [31:0] aAddr;
    logic        bReq;
    logic        bWe;
    logic        bLock;
    logic [31:0] bAddr;
  } stim_t;

  typedef struct {
    stim_t in;
    logic  expAGnt;
    logic  expBGnt;
    logic  expStall;
    logic  expARv;
    logic  expBRv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, memRead2, memWrite2, memSign;
  logic [31:0] memAddr2, memDin2, memDout2;
  logic [1:0]  memSize;

  int checks = 0;
  int failures = 0;

  // reference model: rule-level view of the arbiter history
  int          waitCnt;
  bit          locked;
  int          pendOwner;
  logic [31:0] pendAddr;
  bit          live;

  always #5 clk = ~clk;

  otter_mem2_arbiter_if aIf ();
  otter_mem2_arbiter_if bIf ();

  otter_mem2_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_port     (aIf),
    .b_port     (bIf),
    .stall      (stall),
    .mem_read2  (memRead2),
    .mem_write2 (memWrite2),
    .mem_addr2  (memAddr2),
    .mem_din2   (memDin2),
    .mem_size   (memSize),
    .mem_sign   (memSign),
    .mem_dout2  (memDout2)
  );

  function automatic logic [31:0] memPattern(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0] ^ 16'h5A5A, ~addr[15:0]};
  endfunction

  always @(posedge clk) memDout2 <= memRead2 ? memPattern(memAddr2) : 32'h0;

  function automatic mem_req_t makeCmd(input logic we, input logic [31:0] addr);
    mem_req_t c;
    c.we   = we;
    c.addr = addr;
    c.din  = {addr[15:0], addr[31:16]} ^ 32'h13579BDF;
    c.size = addr[3:2];
    c.sign = addr[4];
    return c;
  endfunction

  function automatic stim_t mk(input logic rstN, input logic aReq, input logic aWe,
                               input logic [31:0] aAddr, input logic bReq, input logic bWe,
                               input logic bLock, input logic [31:0] bAddr);
    stim_t s;
    s.rstN = rstN; s.aReq = aReq; s.aWe = aWe; s.aAddr = aAddr;
    s.bReq = bReq; s.bWe = bWe; s.bLock = bLock; s.bAddr = bAddr;
    return s;
  endfunction

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    waitCnt = 0; locked = 0; pendOwner = 0; pendAddr = 32'h0; live = 0;
  endtask

  // Drives one cycle at the falling edge, checks every output against the
  // model shortly after, then advances the model to the next rising edge.
  task automatic applyStimulus(input stim_t s);
    mem_req_t aCmd, bCmd, expCmd;
    logic aWin, bWin, forced;
    aCmd = makeCmd(s.aWe, s.aAddr);
    bCmd = makeCmd(s.bWe, s.bAddr);
    @(negedge clk);
    rst_n = s.rstN;
    aIf.req = s.aReq; aIf.lock = 1'b0;    aIf.cmd = aCmd;
    bIf.req = s.bReq; bIf.lock = s.bLock; bIf.cmd = bCmd;
    if (!s.rstN) resetModel();
    #1;
    aWin = 1'b0; bWin = 1'b0;
    if (live) begin
      if (locked) begin
        bWin = s.bReq;
      end else begin
        forced = GUARD_EN && s.bReq && (waitCnt == MAX_WAIT);
        aWin = s.aReq && !forced;
        bWin = s.bReq && !aWin;
      end
    end
    expCmd = '0;
    if (aWin) expCmd = aCmd;
    else if (bWin) expCmd = bCmd;
    checkBit("a_gnt", aIf.gnt, aWin);
    checkBit("b_gnt", bIf.gnt, bWin);
    checkBit("stall", stall, s.aReq && !aWin);
    checkBit("mem_read2", memRead2, (aWin || bWin) && !expCmd.we);
    checkBit("mem_write2", memWrite2, (aWin || bWin) && expCmd.we);
    checkOutput("mem_addr2", memAddr2, expCmd.addr);
    checkOutput("mem_din2", memDin2, expCmd.din);
    checkOutput("mem_size", {30'h0, memSize}, {30'h0, expCmd.size});
    checkBit("mem_sign", memSign, expCmd.sign);
    checkBit("a_rvalid", aIf.rvalid, pendOwner == 1);
    checkBit("b_rvalid", bIf.rvalid, pendOwner == 2);
    checkOutput("a_rdata", aIf.rdata, (pendOwner == 1) ? memPattern(pendAddr) : 32'h0);
    checkOutput("b_rdata", bIf.rdata, (pendOwner == 2) ? memPattern(pendAddr) : 32'h0);
    if (s.rstN) begin
      if (bWin || !s.bReq) waitCnt = 0;
      else if (aWin && waitCnt < MAX_WAIT) waitCnt++;
      locked    = locked ? s.bLock : (bWin && s.bLock);
      pendOwner = (aWin && !s.aWe) ? 1 : ((bWin && !s.bWe) ? 2 : 0);
      pendAddr  = aWin ? s.aAddr : s.bAddr;
      live      = 1;
    end
  endtask

  vec_t  tbl [9];
  stim_t idle;

  initial begin
    rst_n = 1'b0;
    aIf.req = 1'b0; aIf.lock = 1'b0; aIf.cmd = '0;
    bIf.req = 1'b0; bIf.lock = 1'b0; bIf.cmd = '0;
    resetModel();
    idle = mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);

    tbl[0] = '{mk(1, 1, 0, 32'h100, 0, 0, 0, 32'h0),  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{idle,                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{mk(1, 0, 0, 32'h0, 1, 0, 0, 32'h20),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{mk(1, 1, 1, 32'h10, 1, 0, 0, 32'h30),  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{mk(1, 0, 0, 32'h0, 1, 0, 0, 32'h30),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{mk(1, 1, 0, 32'h40, 1, 1, 0, 32'h50),  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{mk(1, 1, 0, 32'h44, 1, 1, 0, 32'h50),  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{mk(1, 0, 0, 32'h0, 1, 1, 0, 32'h50),   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{idle,                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset held with B requesting: nothing may be granted
    applyStimulus(mk(0, 0, 0, 32'h0, 1, 0, 0, 32'h20));
    applyStimulus(mk(0, 0, 0, 32'h0, 1, 0, 0, 32'h20));
    applyStimulus(idle);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].in);
      checkBit($sformatf("vec%0d_a_gnt", i), aIf.gnt, tbl[i].expAGnt);
      checkBit($sformatf("vec%0d_b_gnt", i), bIf.gnt, tbl[i].expBGnt);
      checkBit($sformatf("vec%0d_stall", i), stall, tbl[i].expStall);
      checkBit($sformatf("vec%0d_a_rvalid", i), aIf.rvalid, tbl[i].expARv);
      checkBit($sformatf("vec%0d_b_rvalid", i), bIf.rvalid, tbl[i].expBRv);
    end
    checkOutput("vec_a_rdata_deadbeef", 32'hDEADBEEF, memPattern(32'h100));

    // continuous contention: guard lets B through every fifth cycle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk(1, 1, 0, 32'h300 + 32'(i * 4), 1, 0, 0, 32'h400));
      checkBit($sformatf("contend%0d_b_gnt", i), bIf.gnt, GUARD_EN && (i == 4 || i == 9));
      checkBit($sformatf("contend%0d_stall", i), stall, GUARD_EN && (i == 4 || i == 9));
    end
    applyStimulus(idle);

    // lock burst: three B writes while A waits, idle cycle inside the lock
    applyStimulus(mk(1, 0, 0, 32'h0, 1, 1, 1, 32'h200));
    checkBit("lock0_b_gnt", bIf.gnt, 1'b1);
    applyStimulus(mk(1, 1, 0, 32'h80, 1, 1, 1, 32'h204));
    checkBit("lock1_b_gnt", bIf.gnt, 1'b1);
    checkBit("lock1_stall", stall, 1'b1);
    applyStimulus(mk(1, 1, 0, 32'h80, 0, 1, 1, 32'h208));
    checkBit("lock_idle_b_gnt", bIf.gnt, 1'b0);
    checkBit("lock_idle_stall", stall, 1'b1);
    applyStimulus(mk(1, 1, 0, 32'h80, 1, 1, 0, 32'h208));
    checkBit("lock2_b_gnt", bIf.gnt, 1'b1);
    checkBit("lock2_stall", stall, 1'b1);
    applyStimulus(mk(1, 1, 0, 32'h80, 1, 0, 0, 32'h20C));
    checkBit("unlock_a_gnt", aIf.gnt, 1'b1);
    checkBit("unlock_b_gnt", bIf.gnt, 1'b0);
    applyStimulus(idle);

    // interleaved reads: no cross-delivery
    applyStimulus(mk(1, 1, 0, 32'h10, 0, 0, 0, 32'h0));
    applyStimulus(mk(1, 0, 0, 32'h0, 1, 0, 0, 32'h20));
    checkOutput("inter_a_rdata", aIf.rdata, 32'h5A4AFFEF);
    checkOutput("inter_b_rdata_idle", bIf.rdata, 32'h0);
    applyStimulus(idle);
    checkOutput("inter_b_rdata", bIf.rdata, 32'h5A7AFFDF);
    checkOutput("inter_a_rdata_idle", aIf.rdata, 32'h0);
    checkBit("inter_a_rvalid_idle", aIf.rvalid, 1'b0);

    // asynchronous reset while A's read result is pending
    applyStimulus(mk(1, 1, 0, 32'h100, 0, 0, 0, 32'h0));
    @(posedge clk);
    #2;
    checkBit("rst_pre_a_rvalid", aIf.rvalid, 1'b1);
    checkOutput("rst_pre_a_rdata", aIf.rdata, 32'hDEADBEEF);
    aIf.req = 1'b0;
    bIf.req = 1'b1;
    bIf.cmd = makeCmd(1'b0, 32'h20);
    rst_n = 1'b0;
    #1;
    resetModel();
    checkBit("rst_a_rvalid", aIf.rvalid, 1'b0);
    checkOutput("rst_a_rdata", aIf.rdata, 32'h0);
    checkBit("rst_b_gnt", bIf.gnt, 1'b0);
    checkBit("rst_mem_read2", memRead2, 1'b0);
    checkOutput("rst_mem_addr2", memAddr2, 32'h0);
    checkBit("rst_stall", stall, 1'b0);
    applyStimulus(mk(0, 1, 0, 32'h100, 1, 0, 0, 32'h20));
    applyStimulus(mk(1, 1, 0, 32'h100, 1, 0, 0, 32'h20));
    applyStimulus(mk(1, 1, 0, 32'h100, 1, 0, 0, 32'h20));
    checkBit("rst_release_a_gnt", aIf.gnt, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s.rstN  = 1'b1;
      s.aReq  = ($urandom_range(0, 3) != 0);
      s.aWe   = $urandom_range(0, 1) == 1;
      s.aAddr = $urandom;
      s.bReq  = $urandom_range(0, 1) == 1;
      s.bWe   = $urandom_range(0, 1) == 1;
      s.bLock = ($urandom_range(0, 3) == 0);
      s.bAddr = $urandom;
      applyStimulus(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
